// File: rtl/lm71_pkg.sv
// lm71_pkg: shared types and constants for the LM71 serial-sensor responder.
//   lm71_state_t        - responder FSM states
//   LM71_FRAME_BITS     - bits per read half and per write half of a frame
//   LM71_CMD_SHUTDOWN   - write word that enters shutdown
//   LM71_CMD_CONTINUOUS - write word that returns to continuous conversion
//   LM71_TRAIL_BITS     - constant LSBs appended to the 14-bit temperature
package lm71_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_HOLD
  } lm71_state_t;

  localparam int          LM71_FRAME_BITS     = 16;
  localparam logic [15:0] LM71_CMD_SHUTDOWN   = 16'hFFFF;
  localparam logic [15:0] LM71_CMD_CONTINUOUS = 16'h0000;
  localparam logic [1:0]  LM71_TRAIL_BITS     = 2'b11;

endpackage

// File: rtl/lm71_sync_edge.sv
// lm71_sync_edge: multi-flop synchronizer plus edge detector for one
// asynchronous pin.
//   clk, reset_n : system clock, async active-low reset
//   d            : asynchronous input pin
//   q            : synchronized level
//   rise, fall   : one-clk pulses on synchronized edges
// SYNC_STAGES must be at least 2. RESET_VAL is the pin's idle level, so
// leaving reset does not produce a spurious edge.
module lm71_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= {SYNC_STAGES{RESET_VAL}};
      prev <= RESET_VAL;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign q    = sync[SYNC_STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/lm71_responder.sv
// lm71_responder: sensor-side emulation of the LM71 3-wire temperature bus.
// Ports:
//   clk, reset_n     : system clock, async active-low reset
//   cs_n, sc         : chip select / serial clock from the master (async)
//   sio_i            : SIO input from the pad
//   sio_o, sio_oe    : SIO output data / output enable (1 = drive pad)
//   temp_data[13:0]  : two's complement temperature, 0.03125 C/LSB
//   shutdown         : 1 = shutdown mode (reads return MFG_ID)
//   busy             : synchronized, inverted cs_n
//   frame_cnt[15:0]  : complete-read counter, present only when
//                      LM71_RESP_FRAME_CNT_EN is defined
// A frame is 16 read bits (responder shifts out on sc fall) followed by 16
// write bits (responder samples on sc rise). A cs_n rise aborts anywhere.
module lm71_responder
  import lm71_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] MFG_ID      = 16'h800F
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cs_n,
  input  logic        sc,
  input  logic        sio_i,
  output logic        sio_o,
  output logic        sio_oe,
  input  logic [13:0] temp_data,
  output logic        shutdown,
  output logic        busy
`ifdef LM71_RESP_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam logic [3:0] LAST_BIT = 4'(LM71_FRAME_BITS - 1);

  logic cs_q, cs_rise, cs_fall;
  logic sc_level_unused, sc_rise, sc_fall;

  lm71_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .reset_n(reset_n), .d(cs_n),
    .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );

  lm71_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sc_sync (
    .clk(clk), .reset_n(reset_n), .d(sc),
    .q(sc_level_unused), .rise(sc_rise), .fall(sc_fall)
  );

  assign busy = ~cs_q;

  lm71_state_t state;
  logic [15:0] shreg;
  logic [15:0] cmd;
  logic [3:0]  bit_cnt;
  logic        sampled;   // master has clocked the current bit in
  logic [15:0] load_word;
  logic [15:0] cmd_next;

  assign load_word = shutdown ? MFG_ID : {temp_data, LM71_TRAIL_BITS};
  assign cmd_next  = {cmd[14:0], sio_i};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      cmd      <= '0;
      bit_cnt  <= '0;
      sampled  <= 1'b0;
      sio_o    <= 1'b0;
      sio_oe   <= 1'b0;
      shutdown <= 1'b0;
    end else if (cs_rise) begin
      // Abort or normal end: release the pad, drop any partial command.
      state   <= ST_IDLE;
      bit_cnt <= '0;
      sampled <= 1'b0;
      sio_o   <= 1'b0;
      sio_oe  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            shreg   <= load_word;
            sio_o   <= load_word[15];
            sio_oe  <= 1'b1;
            bit_cnt <= '0;
            sampled <= 1'b0;
            state   <= ST_READ;
          end
        end
        ST_READ: begin
          if (sc_rise) begin
            sampled <= 1'b1;
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              cmd     <= '0;
              state   <= ST_WRITE;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else if (sc_fall && sampled) begin
            // Only shift once the bit on the wire has been clocked in, so a
            // master whose sc idles high does not lose the MSB.
            shreg   <= {shreg[14:0], 1'b0};
            sio_o   <= shreg[14];
            sampled <= 1'b0;
          end
        end
        ST_WRITE: begin
          // Keep driving bit 0 through the 16th high phase.
          if (sc_fall) begin
            sio_oe <= 1'b0;
            sio_o  <= 1'b0;
          end
          if (sc_rise) begin
            cmd <= cmd_next;
            if (bit_cnt == LAST_BIT) begin
              if (cmd_next == LM71_CMD_SHUTDOWN)
                shutdown <= 1'b1;
              else if (cmd_next == LM71_CMD_CONTINUOUS)
                shutdown <= 1'b0;
              bit_cnt <= '0;
              state   <= ST_HOLD;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        ST_HOLD: ;
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef LM71_RESP_FRAME_CNT_EN
  // Reaching WRITE or HOLD means all 16 read bits were clocked out.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      frame_cnt <= '0;
    else if (cs_rise && (state == ST_WRITE || state == ST_HOLD))
      frame_cnt <= frame_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_lm71_responder.sv
// tb_lm71_responder: table-driven frame tests with a scoreboard of expected
// read words, plus hand-written abort and mid-frame reset sequences.
module tb_lm71_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cs_n = 1'b1;
  logic        sc = 1'b0;
  logic        sio_i = 1'b0;
  logic        sio_o, sio_oe, shutdown, busy;
  logic [13:0] temp_data = '0;
`ifdef LM71_RESP_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  lm71_responder dut (
    .clk(clk), .reset_n(reset_n), .cs_n(cs_n), .sc(sc), .sio_i(sio_i),
    .sio_o(sio_o), .sio_oe(sio_oe), .temp_data(temp_data),
    .shutdown(shutdown), .busy(busy)
`ifdef LM71_RESP_FRAME_CNT_EN
    , .frame_cnt(frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_fc = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance n clocks, then move off the edge before driving or sampling.
  task automatic wc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // One frame as the master sees it, sc at clk/10, idling low.
  task automatic frame(input logic [13:0] t, input int rd_bits,
                       input int wr_bits, input logic [15:0] wcmd,
                       output logic [15:0] word);
    word = '0;
    temp_data = t;
    cs_n = 1'b0;
    wc(3);
    chk("oe_after_cs_fall", sio_oe, 1'b1);
    wc(3);
    chk("busy", busy, 1'b1);
    temp_data = ~t;   // must not disturb the frame in flight
    for (int i = 0; i < rd_bits; i++) begin
      word = {word[14:0], sio_o};
      sc = 1'b1;
      wc(5);
      if (i == 15) chk("oe_held_bit16", sio_oe, 1'b1);
      sc = 1'b0;
      wc(5);
      if (i == 15) chk("oe_drop_after_bit16", sio_oe, 1'b0);
    end
    for (int j = 0; j < wr_bits; j++) begin
      sio_i = wcmd[15-j];
      sc = 1'b1;
      wc(5);
      sc = 1'b0;
      wc(5);
    end
    sio_i = 1'b0;
    if (rd_bits == 16) exp_fc++;
    cs_n = 1'b1;
    wc(3);
    chk("oe_release_cs_rise", sio_oe, 1'b0);
    wc(3);
    chk("busy_idle", busy, 1'b0);
  endtask

  typedef struct {
    logic [13:0] temp;
    int          wr_bits;
    logic [15:0] wcmd;
    logic [15:0] exp_word;
    logic        exp_sd;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [15:0] word, exp;

    vecs[0] = '{14'h0320, 0,  16'h0000, 16'h0C83, 1'b0};  // +25 C
    vecs[1] = '{14'h3CE0, 16, 16'h1234, 16'hF383, 1'b0};  // -25 C, bad cmd
    vecs[2] = '{14'h0320, 16, 16'hFFFF, 16'h0C83, 1'b1};  // enter shutdown
    vecs[3] = '{14'h0320, 0,  16'h0000, 16'h800F, 1'b1};  // MFG id
    vecs[4] = '{14'h1FFF, 16, 16'h0000, 16'h800F, 1'b0};  // leave shutdown
    vecs[5] = '{14'h1FFF, 16, 16'h1234, 16'h7FFF, 1'b0};  // max positive
    vecs[6] = '{14'h2000, 0,  16'h0000, 16'h8003, 1'b0};  // most negative

    wc(1);
    chk("rst_sio_o", sio_o, 1'b0);
    chk("rst_sio_oe", sio_oe, 1'b0);
    chk("rst_shutdown", shutdown, 1'b0);
    chk("rst_busy", busy, 1'b0);
    wc(2);
    reset_n = 1'b1;
    wc(4);
    chk("idle_oe", sio_oe, 1'b0);
`ifdef LM71_RESP_FRAME_CNT_EN
    chk("rst_frame_cnt", frame_cnt, 16'd0);
`endif

    for (int k = 0; k < 7; k++) begin
      exp_q.push_back(vecs[k].exp_word);
      frame(vecs[k].temp, 16, vecs[k].wr_bits, vecs[k].wcmd, word);
      exp = exp_q.pop_front();
      chk($sformatf("word_v%0d", k), word, exp);
      chk($sformatf("shutdown_v%0d", k), shutdown, vecs[k].exp_sd);
`ifdef LM71_RESP_FRAME_CNT_EN
      chk($sformatf("frame_cnt_v%0d", k), frame_cnt, 16'(exp_fc));
`endif
    end

    // Aborted read after 7 bits, then aborted write after 5 bits of FFFF.
    frame(14'h0320, 7, 0, 16'h0000, word);
    chk("abort_rd_shutdown", shutdown, 1'b0);
    frame(14'h0320, 16, 5, 16'hFFFF, word);
    chk("abort_wr_shutdown", shutdown, 1'b0);
`ifdef LM71_RESP_FRAME_CNT_EN
    chk("frame_cnt_abort", frame_cnt, 16'(exp_fc));
`endif

    // Enter shutdown, then reset during bit 9 of the next read.
    frame(14'h0320, 16, 16, 16'hFFFF, word);
    chk("pre_reset_shutdown", shutdown, 1'b1);
    cs_n = 1'b0;
    wc(6);
    for (int i = 0; i < 8; i++) begin
      sc = 1'b1; wc(5);
      sc = 1'b0; wc(5);
    end
    sc = 1'b1;
    wc(2);
    chk("oe_before_reset", sio_oe, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("reset_oe_immediate", sio_oe, 1'b0);
    chk("reset_shutdown", shutdown, 1'b0);
    sc = 1'b0;
    cs_n = 1'b1;
    wc(3);
    reset_n = 1'b1;
    exp_fc = 0;
    wc(4);
    exp_q.push_back(16'h0C83);
    frame(14'h0320, 16, 0, 16'h0000, word);
    exp = exp_q.pop_front();
    chk("word_after_reset", word, exp);
`ifdef LM71_RESP_FRAME_CNT_EN
    chk("frame_cnt_after_reset", frame_cnt, 16'(exp_fc));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lm71_responder.md
# lm71_responder

Synthesizable responder for the LM71 3-wire serial temperature interface. It emulates the sensor side of the bus that the `temp_lm71cimf` master drives, so the master and its Qsys software can be exercised in hardware-in-loop tests and in simulation without a physical sensor. It sits between the top-level `TEMP_CS_n`/`TEMP_SC`/`TEMP_SIO` pins, or the master's conduit, and a register or test source that supplies the temperature value.

## Interface
Parameters:
- `SYNC_STAGES`, 2: number of flops in the synchronizer on `cs_n` and `sc`.
- `MFG_ID`, 16'h800F: word returned on reads while the block is in shutdown.

Ports:
- `clk`, in, 1: system clock (50 MHz on DECA).
- `reset_n`, in, 1: asynchronous, active-low reset.
- `cs_n`, in, 1: chip select from the master, asynchronous to `clk`.
- `sc`, in, 1: serial clock from the master, asynchronous to `clk`.
- `sio_i`, in, 1: SIO input path from the pad tristate.
- `sio_o`, out, 1: SIO output data.
- `sio_oe`, out, 1: SIO output enable. 1 means the responder drives the pad.
- `temp_data`, in, 14: temperature in two's complement at 0.03125 °C/LSB.
- `shutdown`, out, 1: current mode. 1 means shutdown, 0 means continuous conversion.
- `busy`, out, 1: high while a frame is in progress (CS low).

## Operation
- `cs_n` and `sc` each pass through a `SYNC_STAGES`-flop synchronizer and an edge detector. All logic runs on `clk` only.
- State machine states: IDLE, READ, WRITE, HOLD.
- IDLE, on a synchronized `cs_n` fall:
  - Latch the shift register with `{temp_data, 2'b11}`, or with `MFG_ID` when `shutdown`=1.
  - Set `sio_oe`=1 and drive the MSB on `sio_o`.
  - Clear the bit counter and go to READ.
- READ:
  - On each `sc` falling edge, shift left and present the next bit.
  - The master samples on `sc` rising edges.
  - After the 16th rising edge, go to WRITE. `sio_oe` drops on the next `sc` falling edge, not before.
- WRITE:
  - On each `sc` rising edge, shift `sio_i` into the command register, MSB first.
  - After 16 bits, decode the command:
    - 16'hFFFF sets `shutdown`=1.
    - 16'h0000 sets `shutdown`=0.
    - Any other value is ignored.
  - Then go to HOLD.
- HOLD: ignore `sc` until `cs_n` rises.
- A `cs_n` rise in any state forces IDLE on the same cycle the edge is detected, with `sio_oe`=0. A partial write frame is discarded and `shutdown` is unchanged.
- `busy` equals the synchronized, inverted `cs_n`.
- `temp_data` is sampled only at the `cs_n` fall. Later changes do not affect the frame in flight.

## Timing
- Reset values: `sio_o`=0, `sio_oe`=0, `shutdown`=0, `busy`=0. State is IDLE and all counters are 0.
- Input-to-action latency is `SYNC_STAGES`+1 `clk` cycles from a pin edge to the resulting state or output change.
- The MSB is valid `SYNC_STAGES`+1 cycles after `cs_n` falls. The master must allow at least 100 ns (5 `clk` cycles) from CS fall to the first `sc` rise.
- Supported `sc` rate is at most `clk`/8, with each `sc` phase lasting at least 4 `clk` cycles. The DECA master runs well below this.
- A data bit changes `SYNC_STAGES`+1 cycles after the `sc` fall. This stays well inside the low phase.
- `reset_n` assertion mid-frame immediately releases SIO (`sio_oe`=0) and clears `shutdown`.

## Configuration
- `LM71_RESP_FRAME_CNT_EN`, when defined:
  - Adds output `frame_cnt` [15:0]. It resets to 0 and increments by 1 at every `cs_n` rise that ends a complete 16-bit read.
  - It wraps from 16'hFFFF to 0.
- When undefined, the port and the counter are absent. Behaviour is otherwise identical.

## Structure
- Package `lm71_pkg` holds:
  - The state enum `lm71_state_t`.
  - `LM71_FRAME_BITS`=16.
  - `LM71_CMD_SHUTDOWN`=16'hFFFF and `LM71_CMD_CONTINUOUS`=16'h0000.
  - `LM71_TRAIL_BITS`=2'b11.
- Sub-module `lm71_sync_edge` contains the synchronizer plus rise/fall pulse generation. It is instantiated once for `cs_n` and once for `sc`.
- The top-level pad tristate stays outside this block. The block only exports `sio_o`/`sio_oe`/`sio_i`.

## Test plan
- +25 °C read:
  - Stimulus: `temp_data`=14'h0320, one full read frame at `clk`/10.
  - Required response: master receives 16'h0C83 and `sio_oe` returns to 0 after the 16th bit.
- −25 °C read:
  - Stimulus: `temp_data`=14'h3CE0.
  - Required response: master receives 16'hF383.
- Shutdown:
  - Stimulus: read, then write 16'hFFFF, raise CS.
  - Required response: `shutdown`=1. The next read returns 16'h800F.
  - Stimulus: write 16'h0000.
  - Required response: `shutdown`=0 and the following read returns the temperature again.
- Aborted frame:
  - Stimulus: raise `cs_n` after 7 read bits, then again after 5 write bits of 16'hFFFF.
  - Required response: `sio_oe`=0 within 3 cycles of each rise and `shutdown` stays 0.
- Invalid command:
  - Stimulus: write 16'h1234.
  - Required response: `shutdown` unchanged. With `LM71_RESP_FRAME_CNT_EN`, 3 complete reads give `frame_cnt`=3.
- Reset mid-READ:
  - Stimulus: pulse `reset_n` low during bit 9.
  - Required response: `sio_oe`=0 immediately. The next frame starts cleanly with the MSB.
